// File: rtl/byte_enable_memory.sv
// byte_enable_memory: single-port word memory, per-byte write enables, pipelined reads.
// Latency: a read returns ReadLatency cycles after its accept cycle; writes produce no response.
// Backpressure: none in RUN (ReqReady held high); requests are refused only during INIT.
//
// Ports:
//   Clock, Reset       rising-edge clock, synchronous active-high reset
//   ReqValid/ReqReady  request handshake (accept = ReqValid & ReqReady)
//   Status             0 = read, 1 = write
//   Address, ByteEn, I word address, write byte mask, write data
//   RespValid, Q       read response (Q is forced to 0 when RespValid is low)
//   InitDone           memory ready for traffic
//
// Optional feature: define MEM_ZERO_INIT_EN to clear every word after reset
// (one word per cycle) before leaving INIT. Without it INIT lasts one cycle and
// the array keeps its contents across reset.
module byte_enable_memory #(
  parameter int WordSize        = 32,
  parameter int WordsNumberLog2 = 8,
  parameter int ReadLatency     = 1
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       ReqValid,
  output logic                       ReqReady,
  input  logic                       Status,
  input  logic [WordsNumberLog2-1:0] Address,
  input  logic [WordSize/8-1:0]      ByteEn,
  input  logic [WordSize-1:0]        I,
  output logic                       RespValid,
  output logic [WordSize-1:0]        Q,
  output logic                       InitDone
);

  localparam int ByteCount = WordSize / 8;
  localparam int Depth     = 1 << WordsNumberLog2;

  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]                 state_q, state_d;
  logic [WordSize-1:0]        mem_q [Depth];
  logic [ReadLatency-1:0]     rvld_q;
  logic [WordSize-1:0]        rdat_q [ReadLatency];
  logic                       rd_acc, wr_acc;
  logic                       clr_en;
  logic [WordsNumberLog2-1:0] clr_addr;

  assign ReqReady = (state_q == StRun);
  assign InitDone = (state_q == StRun);

  // A request presented in the same cycle as Reset is dropped so nothing
  // commits while the block is being re-initialised.
  assign rd_acc = ReqValid & ReqReady & ~Status & ~Reset;
  assign wr_acc = ReqValid & ReqReady &  Status & ~Reset;

`ifdef MEM_ZERO_INIT_EN
  logic [WordsNumberLog2-1:0] sweep_q, sweep_d;

  // Sweep counter walks every word once; its wrap back to 0 ends INIT.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == StInit) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == '1) begin
        state_d = StRun;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StInit;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  assign clr_en   = (state_q == StInit) & ~Reset;
  assign clr_addr = sweep_q;
`else
  always_comb begin
    state_d = state_q;
    if (state_q == StInit) begin
      state_d = StRun;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  assign clr_en   = 1'b0;
  assign clr_addr = '0;
`endif

  // Array is not reset: contents either survive reset or are swept to zero.
  always_ff @(posedge Clock) begin
    if (clr_en) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_acc) begin
      for (int k = 0; k < ByteCount; k++) begin
        if (ByteEn[k]) begin
          mem_q[Address][8*k +: 8] <= I[8*k +: 8];
        end
      end
    end
  end

  // Read pipeline: stage 0 captures the array word on the accept edge, so a
  // later write cannot disturb an in-flight read. Non-read slots carry zero,
  // which keeps Q at 0 whenever RespValid is low.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rvld_q <= '0;
      for (int s = 0; s < ReadLatency; s++) begin
        rdat_q[s] <= '0;
      end
    end else begin
      rvld_q[0] <= rd_acc;
      rdat_q[0] <= rd_acc ? mem_q[Address] : '0;
      for (int s = 1; s < ReadLatency; s++) begin
        rvld_q[s] <= rvld_q[s-1];
        rdat_q[s] <= rdat_q[s-1];
      end
    end
  end

  assign RespValid = rvld_q[ReadLatency-1];
  assign Q         = rdat_q[ReadLatency-1];

endmodule

// File: tb/tb_byte_enable_memory.sv
module tb_byte_enable_memory;

  localparam int W  = 32;
  localparam int AW = 4;
  localparam int L  = 3;
  localparam int DEPTH = 1 << AW;
`ifdef MEM_ZERO_INIT_EN
  localparam int INIT_LEN = 16;
`else
  localparam int INIT_LEN = 1;
`endif

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          ReqValid = 1'b0;
  logic          ReqReady;
  logic          Status = 1'b0;
  logic [AW-1:0] Address = '0;
  logic [3:0]    ByteEn = '0;
  logic [W-1:0]  I = '0;
  logic          RespValid;
  logic [W-1:0]  Q;
  logic          InitDone;

  byte_enable_memory #(.WordSize(W), .WordsNumberLog2(AW), .ReadLatency(L)) dut (
    .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .Status(Status), .Address(Address), .ByteEn(ByteEn), .I(I),
    .RespValid(RespValid), .Q(Q), .InitDone(InitDone)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // gcyc numbers the cycle between posedges; n counts cycles since the last
  // reset edge (saturating). Ready exactly when n >= INIT_LEN.
  int           gcyc = 0;
  int           n = 0;
  bit           started = 0;
  logic [31:0]  mmem [DEPTH];
  logic [3:0]   kn   [DEPTH];
  logic [31:0]  exp_dat [int];
  logic [31:0]  exp_msk [int];
  logic [31:0]  got_q [$];
  int           got_c [$];

  initial for (int a = 0; a < DEPTH; a++) begin mmem[a] = '0; kn[a] = '0; end

  function automatic logic [31:0] byte_mask(input logic [3:0] k);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (k[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  always @(posedge Clock) begin
    if (Reset) begin
      started = 1;
      n = 0;
      exp_dat.delete();
      exp_msk.delete();
    end else if (started) begin
      if (n < INIT_LEN) begin
`ifdef MEM_ZERO_INIT_EN
        mmem[n] = '0;
        kn[n]   = 4'hF;
`endif
      end else if (ReqValid) begin
        if (Status) begin
          for (int b = 0; b < 4; b++) if (ByteEn[b]) begin
            mmem[Address][8*b +: 8] = I[8*b +: 8];
            kn[Address][b] = 1'b1;
          end
        end else begin
          exp_dat[gcyc + L] = mmem[Address];
          exp_msk[gcyc + L] = byte_mask(kn[Address]);
        end
      end
      if (n <= INIT_LEN) n++;
    end
    gcyc++;
  end

  // Single compare process: every cycle after the first reset edge.
  always @(negedge Clock) begin
    if (started) begin
      chk("ReqReady", {31'b0, ReqReady}, {31'b0, n >= INIT_LEN});
      chk("InitDone", {31'b0, InitDone}, {31'b0, n >= INIT_LEN});
      if (exp_dat.exists(gcyc)) begin
        chk("RespValid", {31'b0, RespValid}, 32'd1);
        chk("Q", Q & exp_msk[gcyc], exp_dat[gcyc] & exp_msk[gcyc]);
        exp_dat.delete(gcyc);
        exp_msk.delete(gcyc);
      end else begin
        chk("RespValid_idle", {31'b0, RespValid}, 32'd0);
        chk("Q_idle", Q, 32'd0);
      end
      if (RespValid) begin
        got_q.push_back(Q);
        got_c.push_back(gcyc);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset;
    Reset = 1'b1;
    step;
    step;
    Reset = 1'b0;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!ReqReady && cnt < 64) begin
      step;
      cnt++;
    end
  endtask

  task automatic do_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    ReqValid = 1'b1; Status = 1'b1; Address = a; I = d; ByteEn = be;
    step;
    ReqValid = 1'b0;
  endtask

  task automatic do_rd(input logic [AW-1:0] a, output int acc_cyc);
    ReqValid = 1'b1; Status = 1'b0; Address = a; ByteEn = $urandom; I = $urandom;
    acc_cyc = gcyc;
    step;
    ReqValid = 1'b0;
  endtask

  task automatic idle(input int c);
    for (int i = 0; i < c; i++) step;
  endtask

  initial begin
    int cnt, ac, ac2;

    // Reset state and INIT length.
    do_reset;
    chk("rst_ReqReady", {31'b0, ReqReady}, 32'd0);
    chk("rst_Q", Q, 32'd0);
    wait_ready(cnt);
    chk("init_len", cnt, INIT_LEN);

`ifdef MEM_ZERO_INIT_EN
    // Every word reads back as zero after the sweep.
    got_q.delete();
    for (int a = 0; a < DEPTH; a++) do_rd(a[AW-1:0], ac);
    idle(L + 2);
    chk("zero_cnt", got_q.size(), DEPTH);
    foreach (got_q[i]) chk("zero_val", got_q[i], 32'd0);
`endif

    for (int a = 0; a < DEPTH; a++) do_wr(a[AW-1:0], $urandom, 4'hF);

    // Byte-merge of two writes.
    do_wr(5, 32'hDEADBEEF, 4'b1111);
    do_wr(5, 32'h11223344, 4'b0101);
    got_q.delete(); got_c.delete();
    do_rd(5, ac);
    idle(L + 2);
    chk("merge_cnt", got_q.size(), 1);
    if (got_q.size() == 1) begin
      chk("merge_val", got_q[0], 32'hDE22BE44);
      chk("merge_lat", got_c[0], ac + 3);
    end

    // Back-to-back reads stream out in order.
    do_wr(1, 32'hA, 4'hF);
    do_wr(2, 32'hB, 4'hF);
    do_wr(3, 32'hC, 4'hF);
    got_q.delete(); got_c.delete();
    do_rd(1, ac);
    do_rd(2, ac2);
    do_rd(3, ac2);
    idle(L + 2);
    chk("b2b_cnt", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("b2b_0", got_q[0], 32'hA);
      chk("b2b_1", got_q[1], 32'hB);
      chk("b2b_2", got_q[2], 32'hC);
      chk("b2b_first", got_c[0], ac + 3);
      chk("b2b_last", got_c[2], ac + 5);
    end

    // Read, write same word, read: old then new, bubble between.
    do_wr(7, 32'h1, 4'hF);
    got_q.delete(); got_c.delete();
    do_rd(7, ac);
    do_wr(7, 32'h2, 4'hF);
    do_rd(7, ac2);
    idle(L + 2);
    chk("rw_cnt", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("rw_old", got_q[0], 32'h1);
      chk("rw_new", got_q[1], 32'h2);
      chk("rw_gap", got_c[1] - got_c[0], 2);
    end

    // Reset right after a read accept flushes the response.
    do_wr(9, 32'hCAFEF00D, 4'hF);
    got_q.delete(); got_c.delete();
    do_rd(2, ac);
    Reset = 1'b1;
    step;
    Reset = 1'b0;
    wait_ready(cnt);
    chk("flush_init_len", cnt, INIT_LEN);
    chk("flush_cnt", got_q.size(), 0);

    // Request held across INIT; ByteEn=0 write is a no-op.
    ReqValid = 1'b1; Status = 1'b1; Address = 9; ByteEn = 4'b0000; I = 32'hFFFFFFFF;
    do_reset;
    wait_ready(cnt);
    chk("held_init_len", cnt, INIT_LEN);
    step;
    ReqValid = 1'b0;
    got_q.delete();
    do_rd(9, ac);
    idle(L + 2);
    chk("nowr_cnt", got_q.size(), 1);
    if (got_q.size() == 1) begin
`ifdef MEM_ZERO_INIT_EN
      chk("nowr_val", got_q[0], 32'h0);
`else
      chk("nowr_val", got_q[0], 32'hCAFEF00D);
`endif
    end

    // Randomised traffic, with occasional resets.
    for (int a = 0; a < DEPTH; a++) do_wr(a[AW-1:0], $urandom, 4'hF);
    for (int i = 0; i < 600; i++) begin
      Reset    = ($urandom_range(0, 199) == 0);
      ReqValid = ($urandom_range(0, 3) != 0);
      Status   = $urandom_range(0, 1);
      Address  = $urandom;
      ByteEn   = $urandom;
      I        = $urandom;
      step;
    end
    Reset = 1'b0;
    ReqValid = 1'b0;
    idle(INIT_LEN + L + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
